// File: rtl/midi_pitch_selector_if.sv
// Bus between the MIDI/ADC front end (master) and midi_pitch_selector (slave).
// midi_valid/adc_valid are single-cycle strobes with no ready: the slave always accepts a strobe on the edge where it is high.
interface midi_pitch_selector_if #(
  parameter int ADC_W   = 12,
  parameter int DELAY_W = 11
);
  logic               midi_valid;
  logic [6:0]         input_midi_note;
  logic               adc_valid;
  logic [ADC_W-1:0]   adc_read;
  logic [1:0]         octave_switch;
  logic               midi_mode_switch;
  logic               tick_en;
  logic [DELAY_W-1:0] delay_out;
  logic [3:0]         octave_out;
  logic [6:0]         note_out;
  logic               note_changed;
  logic [9:0]         led;
  logic [6:0]         hex0;
  logic [6:0]         hex1;

  modport master (
    output midi_valid, input_midi_note, adc_valid, adc_read, octave_switch, midi_mode_switch,
    input  tick_en, delay_out, octave_out, note_out, note_changed, led, hex0, hex1
  );
  modport slave (
    input  midi_valid, input_midi_note, adc_valid, adc_read, octave_switch, midi_mode_switch,
    output tick_en, delay_out, octave_out, note_out, note_changed, led, hex0, hex1
  );
endinterface

// File: rtl/midi_pitch_selector.sv
// Note source select (MIDI latch or debounced ADC) -> oscillator delay, octave tick enable, 7-seg codes.
// Optional glide of delay_out enabled by defining MIDI_PITCH_GLIDE_EN.
module midi_pitch_selector #(
  parameter int ADC_W      = 12,
  parameter int DELAY_W    = 11,
  parameter int STABLE_CNT = 4,
  parameter int GLIDE_RATE = 64
) (
  input logic                  a_clk,
  input logic                  reset_n,
  midi_pitch_selector_if.slave bus
);
  localparam logic [6:0]         RESET_NOTE  = 7'd48;
  localparam logic [DELAY_W-1:0] RESET_DELAY = DELAY_W'(734);
  localparam logic [3:0]         STABLE_TH   = 4'(STABLE_CNT);
  localparam logic [6:0]         FLAT_SEG    = 7'b1111100;

  logic [6:0]         midi_latch, adc_note, prev_cand, note_q;
  logic [3:0]         stable_cnt, cnt_next, octave_q, oct_calc, semi;
  logic [1:0]         sw_q;
  logic [8:0]         presc, tick_mask;
  logic [9:0]         tick_span, base_delay, half_delay;
  logic [7:0]         cand_sum;
  logic [6:0]         cand, src_note, hex0_q, hex1_q;
  logic [DELAY_W-1:0] target, delay_q;
  logic               sw_chg, same_cand, commit, tick_q, changed_q, tick_next;
  logic               unused_adc_bits;

  function automatic logic [6:0] base_of(input logic [1:0] sw);
    case (sw)
      2'b00:   base_of = 7'd24;
      2'b01:   base_of = 7'd36;
      2'b11:   base_of = 7'd48;
      default: base_of = 7'd60;
    endcase
  endfunction

  function automatic logic [3:0] oct_of(input logic [6:0] n);
    oct_of = 4'd0;
    for (int i = 1; i <= 10; i++)
      if (n >= 7'(12 * i)) oct_of = 4'(i);
  endfunction

  function automatic logic [9:0] delay_of(input logic [3:0] s);
    case (s)
      4'd0:    delay_of = 10'd734;
      4'd1:    delay_of = 10'd693;
      4'd2:    delay_of = 10'd654;
      4'd3:    delay_of = 10'd617;
      4'd4:    delay_of = 10'd582;
      4'd5:    delay_of = 10'd550;
      4'd6:    delay_of = 10'd519;
      4'd7:    delay_of = 10'd490;
      4'd8:    delay_of = 10'd462;
      4'd9:    delay_of = 10'd436;
      4'd10:   delay_of = 10'd412;
      default: delay_of = 10'd389;
    endcase
  endfunction

  function automatic logic [6:0] letter_of(input logic [3:0] s);
    case (s)
      4'd0:              letter_of = 7'b0111001;
      4'd1, 4'd2:        letter_of = 7'b1011110;
      4'd3, 4'd4:        letter_of = 7'b1111001;
      4'd5:              letter_of = 7'b1110001;
      4'd6, 4'd7:        letter_of = 7'b1111101;
      4'd8, 4'd9:        letter_of = 7'b1110111;
      default:           letter_of = 7'b1111100;
    endcase
  endfunction

  assign unused_adc_bits = ^bus.adc_read;

  always_comb begin
    cand_sum  = {2'b00, bus.adc_read[ADC_W-1 -: 6]} + {1'b0, base_of(bus.octave_switch)};
    cand      = cand_sum[7] ? 7'd127 : cand_sum[6:0];
    sw_chg    = (bus.octave_switch != sw_q);
    same_cand = (cand == prev_cand) && (stable_cnt != 4'd0) && !sw_chg;
    cnt_next  = stable_cnt;
    if (bus.adc_valid)
      cnt_next = same_cand ? ((stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1) : 4'd1;
    else if (sw_chg)
      cnt_next = 4'd0;
    commit = bus.adc_valid && (cnt_next >= STABLE_TH);
    // Incoming strobes bypass their latches so a note reaches the outputs 2 edges after its strobe.
    if (bus.midi_mode_switch)
      src_note = commit ? cand : adc_note;
    else
      src_note = bus.midi_valid ? bus.input_midi_note : midi_latch;
  end

  always_comb begin
    oct_calc   = oct_of(note_q);
    semi       = 4'(note_q - 7'(oct_calc) * 7'd12);
    base_delay = delay_of(semi);
    half_delay = 10'(({1'b0, base_delay} + 11'd1) >> 1);
    target     = (oct_calc == 4'd10) ? DELAY_W'(half_delay) : DELAY_W'(base_delay);
    tick_span  = 10'd1 << (4'd9 - oct_calc);
    tick_mask  = 9'(tick_span - 10'd1);
    tick_next  = (oct_calc >= 4'd9) || ((presc & tick_mask) == 9'd0);
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      presc      <= 9'd0;
      midi_latch <= RESET_NOTE;
      adc_note   <= RESET_NOTE;
      prev_cand  <= 7'd0;
      stable_cnt <= 4'd0;
      sw_q       <= 2'b00;
      note_q     <= RESET_NOTE;
      changed_q  <= 1'b0;
      octave_q   <= 4'd4;
      hex0_q     <= 7'd0;
      hex1_q     <= 7'd0;
      tick_q     <= 1'b0;
    end else begin
      presc      <= presc + 9'd1;
      sw_q       <= bus.octave_switch;
      stable_cnt <= cnt_next;
      if (bus.midi_valid) midi_latch <= bus.input_midi_note;
      if (bus.adc_valid)  prev_cand  <= cand;
      if (commit)         adc_note   <= cand;
      note_q     <= src_note;
      changed_q  <= (src_note != note_q);
      octave_q   <= oct_calc;
      hex0_q     <= letter_of(semi);
      hex1_q     <= (semi inside {4'd1, 4'd3, 4'd6, 4'd8, 4'd10}) ? FLAT_SEG : 7'd0;
      tick_q     <= tick_next;
    end
  end

`ifdef MIDI_PITCH_GLIDE_EN
  localparam int             GW         = (GLIDE_RATE > 1) ? $clog2(GLIDE_RATE) : 1;
  localparam logic [GW-1:0]  GLIDE_LAST = GW'(GLIDE_RATE - 1);
  logic [GW-1:0]      glide_timer;
  logic [DELAY_W-1:0] target_q;

  // Same-octave target changes slew one count per GLIDE_RATE cycles; octave changes jump.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      delay_q     <= RESET_DELAY;
      target_q    <= RESET_DELAY;
      glide_timer <= '0;
    end else begin
      target_q <= target;
      if (oct_calc != octave_q) begin
        delay_q     <= target;
        glide_timer <= '0;
      end else if (target != target_q) begin
        glide_timer <= '0;
      end else if (delay_q != target) begin
        if (glide_timer == GLIDE_LAST) begin
          glide_timer <= '0;
          delay_q     <= (delay_q > target) ? delay_q - DELAY_W'(1) : delay_q + DELAY_W'(1);
        end else begin
          glide_timer <= glide_timer + GW'(1);
        end
      end
    end
  end
`else
  localparam int unused_glide_rate = GLIDE_RATE;

  always_ff @(posedge a_clk) begin
    if (!reset_n) delay_q <= RESET_DELAY;
    else          delay_q <= target;
  end
`endif

  assign bus.note_out     = note_q;
  assign bus.note_changed = changed_q;
  assign bus.octave_out   = octave_q;
  assign bus.delay_out    = delay_q;
  assign bus.tick_en      = tick_q;
  assign bus.hex0         = hex0_q;
  assign bus.hex1         = hex1_q;
  assign bus.led          = {3'b000, note_q};
endmodule
